// File: rtl/cic_ctrl_pkg.sv
// Shared definitions for the CIC rate sequencer: FSM state encoding and
// the decimation legality rules for each CIC base-rate family.
package cic_ctrl_pkg;

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] LOAD   = 2'd2;
  localparam logic [1:0] SETTLE = 2'd3;

  // Base decimation of the CIC family selected by CICRATE.
  function automatic int cic_base(input int cicrate);
    if (cicrate == 10 || cicrate == 13) return 2;
    else if (cicrate == 5)              return 5;
    else                                return 3;
  endfunction

  // Legal decimations are BASE*{1,2,4,8}; everything else (including 0/1) is rejected.
  function automatic logic cic_dec_legal(input int dec, input int cicrate);
    int b;
    b = cic_base(cicrate);
    return (dec == b) || (dec == 2 * b) || (dec == 4 * b) || (dec == 8 * b);
  endfunction

endpackage

// File: rtl/cic_rate_sequencer_if.sv
// Decimation-change request channel between the host/config path and the sequencer.
interface cic_rate_sequencer_if #(
  parameter int DEC_WIDTH = 6
) ();

  logic [DEC_WIDTH-1:0] req_decimation;
  logic                 req_valid;
  logic                 req_ready;
  logic                 rate_err;

  modport master (
    output req_decimation,
    output req_valid,
    input  req_ready,
    input  rate_err
  );

  modport slave (
    input  req_decimation,
    input  req_valid,
    output req_ready,
    output rate_err
  );

endinterface

// File: rtl/cic_strobe_delay.sv
// Register pipe that delays the "good output" tag so it lines up with the
// CIC output data, which appears a fixed number of cycles after its strobe.
module cic_strobe_delay #(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic tag_in,
  output logic tag_out
);

  logic [DEPTH-1:0] vld_p;

  // Shift the tag one stage per cycle; reset flushes any tags in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  assign tag_out = vld_p[DEPTH-1];

endmodule

// File: rtl/cic_rate_sequencer.sv
// Sequences decimation changes for a variable-rate CIC: a new rate is only
// applied at an output boundary, one input sample is dropped on the load
// cycle, and the transient outputs after a change are blanked.
module cic_rate_sequencer
  import cic_ctrl_pkg::*;
#(
  parameter int CICRATE        = 12,
  parameter int DEC_WIDTH      = 6,
  parameter int DEFAULT_DEC    = 24,
  parameter int SETTLE_OUTPUTS = 5,
  parameter int VALID_DELAY    = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 adc_strobe,
  cic_rate_sequencer_if.slave  req,
  output logic                 cic_in_strobe,
  output logic [DEC_WIDTH-1:0] cic_decimation,
  input  logic                 cic_out_strobe,
  output logic                 out_valid,
  output logic                 busy
);

  localparam int                   SCW         = $clog2(SETTLE_OUTPUTS + 1);
  localparam logic [SCW-1:0]       SETTLE_LAST = SCW'(SETTLE_OUTPUTS - 1);
  localparam logic [DEC_WIDTH-1:0] DEC_RESET   = DEC_WIDTH'(DEFAULT_DEC);

  logic [1:0]           state;
  logic [SCW-1:0]       settle_cnt;
  logic [DEC_WIDTH-1:0] pend_dec;
  logic                 rate_err_q;
  logic                 req_legal;
  logic                 good_tag;

  assign req_legal     = cic_dec_legal(int'(req.req_decimation), CICRATE);
  assign req.req_ready = (state == RUN);
  assign req.rate_err  = rate_err_q;
  assign busy          = (state != RUN);
  assign cic_in_strobe = adc_strobe && (state != LOAD);
  // Old-rate samples (including the one that ends DRAIN) are settled output.
  assign good_tag      = cic_out_strobe && (state == RUN || state == DRAIN);

  // Control FSM: accept requests in RUN, wait for a boundary, load, then blank transients.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= SETTLE;
      cic_decimation <= DEC_RESET;
      settle_cnt     <= '0;
      rate_err_q     <= 1'b0;
    end else begin
      rate_err_q <= 1'b0;
      case (state)
        RUN: begin
          if (req.req_valid) begin
            if (!req_legal)                             rate_err_q <= 1'b1;
            else if (req.req_decimation != cic_decimation) state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (cic_out_strobe) state <= LOAD;
        end
        LOAD: begin
          cic_decimation <= pend_dec;
          settle_cnt     <= '0;
          state          <= SETTLE;
        end
        SETTLE: begin
          if (cic_out_strobe) begin
            settle_cnt <= settle_cnt + 1'b1;
            if (settle_cnt == SETTLE_LAST) state <= RUN;
          end
        end
        default: state <= SETTLE;
      endcase
    end
  end

  // Capture the requested rate when a change is accepted; only read after DRAIN.
  always_ff @(posedge clock) begin
    if (state == RUN && req.req_valid && req_legal) pend_dec <= req.req_decimation;
  end

  cic_strobe_delay #(
    .DEPTH (VALID_DELAY)
  ) u_strobe_delay (
    .clock   (clock),
    .reset   (reset),
    .tag_in  (good_tag),
    .tag_out (out_valid)
  );

endmodule
